// File: rtl/mul_mdc_engine_ctrl.sv
// mul_mdc engine control: kernel launch, 2-entry skid FIFO on the d stream,
// beat counting against the job limit and done/ready reporting.
package mul_mdc_package;

    localparam int unsigned MUL_MDC_CNT_LEN = 1024;
    localparam int unsigned MUL_MDC_CW      = $clog2(MUL_MDC_CNT_LEN) + 1;

    typedef struct packed {
        logic                  clear;
        logic                  enable;
        logic                  start;
        logic [MUL_MDC_CW-1:0] cnt_limit_d;
    } ctrl_engine_t;

    typedef struct packed {
        logic [MUL_MDC_CW-1:0] cnt_d;
        logic                  done;
        logic                  ready;
    } flags_engine_t;

    typedef struct packed {
        logic idle;
    } flags_kernel_adapter_t;

endpackage

module mul_mdc_engine_ctrl
    import mul_mdc_package::*;
#(
    parameter int unsigned CNT_LEN    = MUL_MDC_CNT_LEN,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  ctrl_engine_t          ctrl_i,
    output flags_engine_t         flags_o,
    output logic                  kernel_start_o,
    input  flags_kernel_adapter_t kernel_flags_i,
    input  logic [DATA_WIDTH-1:0] kern_d_data_i,
    input  logic                  kern_d_valid_i,
    output logic                  kern_d_ready_o,
    output logic [DATA_WIDTH-1:0] d_data_o,
    output logic                  d_valid_o,
    input  logic                  d_ready_i
);

    localparam int unsigned CW = $clog2(CNT_LEN) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e                       state_q, state_d;
    logic [1:0][DATA_WIDTH-1:0]   mem_q, mem_d;
    logic                         rd_ptr_q, rd_ptr_d;
    logic                         wr_ptr_q, wr_ptr_d;
    logic [1:0]                   fill_q, fill_d;
    logic [CW-1:0]                in_cnt_q, in_cnt_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [CW-1:0]                limit_q, limit_d;
    logic                         kstart_q, kstart_d;

    logic run_en;
    logic push;
    logic pop;

    // Handshakes only happen in RUN with enable high; beats past the limit stall.
    assign run_en         = (state_q == RUN) && ctrl_i.enable;
    assign kern_d_ready_o = run_en && (fill_q != 2'd2) && (in_cnt_q < limit_q);
    assign d_valid_o      = run_en && (fill_q != 2'd0);
    assign d_data_o       = mem_q[rd_ptr_q];
    assign push           = kern_d_valid_i && kern_d_ready_o;
    assign pop            = d_valid_o && d_ready_i;
    assign kernel_start_o = kstart_q;

    // Flags back to the controller FSM.
    always_comb begin
        flags_o       = '0;
        flags_o.cnt_d = MUL_MDC_CW'(cnt_q);
        flags_o.done  = (state_q == DONE);
        flags_o.ready = (state_q == IDLE) && kernel_flags_i.idle;
    end

    // Next-state logic: FSM, FIFO pointers/occupancy and beat counters.
    always_comb begin
        state_d  = state_q;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        in_cnt_d = in_cnt_q;
        cnt_d    = cnt_q;
        limit_d  = limit_q;
        kstart_d = 1'b0;
        if (ctrl_i.clear) begin
            state_d  = IDLE;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            fill_d   = 2'd0;
            in_cnt_d = '0;
            cnt_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ctrl_i.start && ctrl_i.enable) begin
                        limit_d  = CW'(ctrl_i.cnt_limit_d);
                        in_cnt_d = '0;
                        cnt_d    = '0;
                        if (ctrl_i.cnt_limit_d == '0) begin
                            state_d = DONE;
                        end else begin
                            state_d  = RUN;
                            kstart_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (push) begin
                        mem_d[wr_ptr_q] = kern_d_data_i;
                        wr_ptr_d        = ~wr_ptr_q;
                        in_cnt_d        = in_cnt_q + CW'(1);
                    end
                    if (pop) begin
                        rd_ptr_d = ~rd_ptr_q;
                        cnt_d    = cnt_q + CW'(1);
                        if ((cnt_q + CW'(1)) == limit_q) begin
                            state_d = DONE;
                        end
                    end
                    fill_d = fill_q + {1'b0, push} - {1'b0, pop};
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            mem_q    <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            fill_q   <= 2'd0;
            in_cnt_q <= '0;
            cnt_q    <= '0;
            limit_q  <= '0;
            kstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            in_cnt_q <= in_cnt_d;
            cnt_q    <= cnt_d;
            limit_q  <= limit_d;
            kstart_q <= kstart_d;
        end
    end

endmodule

// File: tb/tb_mul_mdc_engine_ctrl.sv
// Bench for mul_mdc_engine_ctrl: a cycle table for a basic job plus
// directed sequences for back-pressure, overrun, zero limit, clear, stall, reset.
module tb_mul_mdc_engine_ctrl;
    import mul_mdc_package::*;

    logic                  clk;
    logic                  rst_n;
    ctrl_engine_t          ctrl;
    flags_engine_t         flags;
    logic                  kstart;
    flags_kernel_adapter_t kflags;
    logic [31:0]           kdata;
    logic                  kvalid;
    logic                  kready;
    logic [31:0]           ddata;
    logic                  dvalid;
    logic                  dready;

    int errors = 0;
    int checks = 0;

    mul_mdc_engine_ctrl #(
        .CNT_LEN    (1024),
        .DATA_WIDTH (32)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .ctrl_i         (ctrl),
        .flags_o        (flags),
        .kernel_start_o (kstart),
        .kernel_flags_i (kflags),
        .kern_d_data_i  (kdata),
        .kern_d_valid_i (kvalid),
        .kern_d_ready_o (kready),
        .d_data_o       (ddata),
        .d_valid_o      (dvalid),
        .d_ready_i      (dready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [10:0] lim;
        logic        kv;
        logic [31:0] kd;
        logic        dr;
        logic        en;
        logic        clr;
        logic        kidle;
        logic        e_kr;
        logic        e_dv;
        logic [31:0] e_dd;
        logic        e_ks;
        logic        e_done;
        logic        e_rdy;
        logic [10:0] e_cnt;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int lim, input bit toggle, input int offer,
                           input logic [31:0] base, output int acc,
                           output int got, output int dn, output int ks,
                           output int stall);
        acc   = 0;
        got   = 0;
        dn    = 0;
        ks    = 0;
        stall = 0;
        ctrl.start       = 1'b1;
        ctrl.enable      = 1'b1;
        ctrl.clear       = 1'b0;
        ctrl.cnt_limit_d = lim[10:0];
        kvalid = 1'b0;
        dready = 1'b0;
        cyc();
        ctrl.start = 1'b0;
        for (int i = 0; i < 80 && dn == 0; i++) begin
            kvalid = (acc < offer);
            kdata  = base + acc;
            dready = toggle ? i[0] : 1'b1;
            @(negedge clk);
            if (kstart) ks++;
            if (kvalid && !kready && acc < lim) stall++;
            if (kvalid && kready) acc++;
            if (dvalid && dready) begin
                chk("beat_data", ddata, base + got);
                got++;
            end
            if (flags.done) begin
                dn++;
                chk("job_cnt_d", 32'(flags.cnt_d), lim);
            end
            cyc();
        end
        kvalid = 1'b0;
        dready = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", 32'(flags.done), 0);
        chk("ready_after_done", 32'(flags.ready), 1);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, got, dn, ks, stall;

        tbl[0] = '{1, 4, 0, 0,            1, 1, 0, 1, 0, 0, 0,            0, 0, 1, 0};
        tbl[1] = '{0, 4, 1, 32'hA000_0000, 1, 1, 0, 1, 1, 0, 0,            1, 0, 0, 0};
        tbl[2] = '{0, 4, 1, 32'hA000_0001, 1, 1, 0, 1, 1, 1, 32'hA000_0000, 0, 0, 0, 0};
        tbl[3] = '{0, 4, 1, 32'hA000_0002, 1, 1, 0, 1, 1, 1, 32'hA000_0001, 0, 0, 0, 1};
        tbl[4] = '{0, 4, 1, 32'hA000_0003, 1, 1, 0, 1, 1, 1, 32'hA000_0002, 0, 0, 0, 2};
        tbl[5] = '{0, 4, 1, 32'h0000_DEAD, 1, 1, 0, 1, 0, 1, 32'hA000_0003, 0, 0, 0, 3};
        tbl[6] = '{0, 4, 0, 0,            1, 1, 0, 1, 0, 0, 0,            0, 1, 0, 4};
        tbl[7] = '{0, 4, 0, 0,            1, 1, 0, 0, 0, 0, 0,            0, 0, 0, 4};
        tbl[8] = '{0, 4, 0, 0,            1, 1, 0, 1, 0, 0, 0,            0, 0, 1, 4};

        rst_n       = 1'b0;
        ctrl        = '0;
        kflags.idle = 1'b1;
        kdata       = '0;
        kvalid      = 1'b0;
        dready      = 1'b0;
        #3;
        chk("rst_kready", 32'(kready), 0);
        chk("rst_dvalid", 32'(dvalid), 0);
        chk("rst_ddata", ddata, 0);
        chk("rst_kstart", 32'(kstart), 0);
        chk("rst_done", 32'(flags.done), 0);
        chk("rst_ready", 32'(flags.ready), 1);
        chk("rst_cnt_d", 32'(flags.cnt_d), 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 9; i++) begin
            ctrl.start       = tbl[i].start;
            ctrl.cnt_limit_d = tbl[i].lim;
            ctrl.enable      = tbl[i].en;
            ctrl.clear       = tbl[i].clr;
            kvalid           = tbl[i].kv;
            kdata            = tbl[i].kd;
            dready           = tbl[i].dr;
            kflags.idle      = tbl[i].kidle;
            @(negedge clk);
            chk($sformatf("v%0d_kready", i), 32'(kready), 32'(tbl[i].e_kr));
            chk($sformatf("v%0d_dvalid", i), 32'(dvalid), 32'(tbl[i].e_dv));
            if (tbl[i].e_dv)
                chk($sformatf("v%0d_ddata", i), ddata, tbl[i].e_dd);
            chk($sformatf("v%0d_kstart", i), 32'(kstart), 32'(tbl[i].e_ks));
            chk($sformatf("v%0d_done", i), 32'(flags.done), 32'(tbl[i].e_done));
            chk($sformatf("v%0d_ready", i), 32'(flags.ready), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d_cnt_d", i), 32'(flags.cnt_d), 32'(tbl[i].e_cnt));
            cyc();
        end
        kvalid = 1'b0;

        run_job(8, 1'b1, 8, 32'h100, acc, got, dn, ks, stall);
        chk("bp_accepted", acc, 8);
        chk("bp_delivered", got, 8);
        chk("bp_done", dn, 1);
        chk("bp_kstart", ks, 1);
        chk("bp_stalled", 32'(stall > 0), 1);

        run_job(3, 1'b0, 5, 32'h200, acc, got, dn, ks, stall);
        chk("ovr_accepted", acc, 3);
        chk("ovr_delivered", got, 3);
        chk("ovr_done", dn, 1);
        chk("ovr_stall", stall, 0);

        ctrl.start       = 1'b1;
        ctrl.cnt_limit_d = 11'd0;
        cyc();
        ctrl.start = 1'b0;
        @(negedge clk);
        chk("zero_done", 32'(flags.done), 1);
        chk("zero_kstart", 32'(kstart), 0);
        chk("zero_cnt_d", 32'(flags.cnt_d), 0);
        chk("zero_ready_busy", 32'(flags.ready), 0);
        cyc();
        @(negedge clk);
        chk("zero_done_drop", 32'(flags.done), 0);
        chk("zero_ready_back", 32'(flags.ready), 1);
        cyc();

        ctrl.start       = 1'b1;
        ctrl.cnt_limit_d = 11'd10;
        cyc();
        ctrl.start = 1'b0;
        acc = 0;
        got = 0;
        for (int i = 0; i < 40 && got < 5; i++) begin
            kvalid = 1'b1;
            kdata  = 32'h300 + acc;
            dready = 1'b1;
            @(negedge clk);
            if (kvalid && kready) acc++;
            if (dvalid && dready) got++;
            cyc();
        end
        dready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (kvalid && kready) acc++;
            cyc();
        end
        @(negedge clk);
        chk("clr_pre_full", 32'(kready), 0);
        chk("clr_pre_dvalid", 32'(dvalid), 1);
        chk("clr_pre_cnt_d", 32'(flags.cnt_d), 5);
        chk("clr_pre_buffered", acc - got, 2);
        cyc();
        kvalid     = 1'b0;
        ctrl.clear = 1'b1;
        cyc();
        ctrl.clear = 1'b0;
        dready     = 1'b1;
        @(negedge clk);
        chk("clr_ready", 32'(flags.ready), 1);
        chk("clr_dvalid", 32'(dvalid), 0);
        chk("clr_cnt_d", 32'(flags.cnt_d), 0);
        chk("clr_done", 32'(flags.done), 0);
        cyc();
        @(negedge clk);
        chk("clr_done_later", 32'(flags.done), 0);
        cyc();
        run_job(2, 1'b0, 2, 32'h700, acc, got, dn, ks, stall);
        chk("post_clr_delivered", got, 2);
        chk("post_clr_done", dn, 1);
        chk("post_clr_kstart", ks, 1);

        ctrl.start       = 1'b1;
        ctrl.enable      = 1'b1;
        ctrl.cnt_limit_d = 11'd6;
        cyc();
        ctrl.start = 1'b0;
        acc = 0;
        got = 0;
        for (int i = 0; i < 3; i++) begin
            kvalid = 1'b1;
            kdata  = 32'h400 + acc;
            dready = 1'b1;
            @(negedge clk);
            if (kvalid && kready) acc++;
            if (dvalid && dready) got++;
            cyc();
        end
        ctrl.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_kready", 32'(kready), 0);
            chk("stall_dvalid", 32'(dvalid), 0);
            chk("stall_cnt_d", 32'(flags.cnt_d), got);
            cyc();
        end
        ctrl.enable = 1'b1;
        @(negedge clk);
        chk("resume_cnt_d", 32'(flags.cnt_d), got);
        chk("resume_dvalid", 32'(dvalid), 1);
        chk("resume_ddata", ddata, 32'h400 + got);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_kready", 32'(kready), 0);
        chk("arst_dvalid", 32'(dvalid), 0);
        chk("arst_ddata", ddata, 0);
        chk("arst_kstart", 32'(kstart), 0);
        chk("arst_done", 32'(flags.done), 0);
        chk("arst_cnt_d", 32'(flags.cnt_d), 0);
        kvalid = 1'b0;
        dready = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        @(negedge clk);
        chk("arst_ready_after", 32'(flags.ready), 1);
        chk("arst_dvalid_after", 32'(dvalid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_mdc_engine_ctrl.md
# mul_mdc_engine_ctrl

Control and output-buffering stage of the mul_mdc HWPE engine. It sits between the mul_mdc controller FSM, which drives `ctrl_engine_t` and reads `flags_engine_t`, and the MDC kernel / `d` sink stream. It launches the kernel and buffers the kernel's `d` output beats in a 2-entry skid FIFO. It counts delivered beats against `cnt_limit_d` and reports done/ready back to the FSM.

## Interface
- `CNT_LEN`, default `MUL_MDC_CNT_LEN` (1024): maximum beats per job. Counter width is CW = `$clog2(CNT_LEN)+1` (11 bits).
- `DATA_WIDTH`, default 32: width of a `d` stream beat.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `ctrl_i`  in  `ctrl_engine_t`  clear/enable/start/cnt_limit_d. `reg_*` fields are unused here.
- `flags_o`  out  `flags_engine_t`  cnt_d/done/ready.
- `kernel_start_o`  out  1  one-cycle kernel launch pulse.
- `kernel_flags_i`  in  `flags_kernel_adapter_t`  monitored only; `idle` is used for `ready`.
- `kern_d_data_i`  in  DATA_WIDTH  kernel output beat.
- `kern_d_valid_i`  in  1  kernel beat valid.
- `kern_d_ready_o`  out  1  buffer accepts a kernel beat.
- `d_data_o`  out  DATA_WIDTH  beat to the `d` sink.
- `d_valid_o`  out  1  sink beat valid.
- `d_ready_i`  in  1  sink accepts the beat.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, FIFO empty, `in_cnt`=0, `cnt_d`=0, `kernel_start_o`=0, `kern_d_ready_o`=0, `d_valid_o`=0, `d_data_o`=0, `flags_o.done`=0.
  - `flags_o.ready` = (state==IDLE) && `kernel_flags_i.idle`. It is 1 out of reset when the kernel is idle.
- IDLE → RUN: on `start` && `enable`.
  - Latch `cnt_limit_d` into `limit`.
  - Zero `in_cnt` and `cnt_d`.
  - Pulse `kernel_start_o` in the following cycle.
- IDLE → DONE: on `start` with `cnt_limit_d`==0. No kernel start is issued.
- RUN, input side: `kern_d_ready_o` = `enable` && FIFO not full && `in_cnt` < `limit`.
  - Each input handshake pushes the beat and increments `in_cnt`.
  - Kernel beats beyond `limit` are back-pressured and never accepted.
- RUN, output side: `d_valid_o` = FIFO not empty && `enable`. `d_data_o` = FIFO head.
  - Each output handshake pops the head and increments `cnt_d`.
- RUN → DONE: on the output handshake that makes `cnt_d`==`limit`.
- DONE: `flags_o.done`=1 for exactly one cycle, then → IDLE. `cnt_d` holds its final value until the next start.
- `enable`=0 freezes all state, counters and FIFO. Both valid/ready outputs are forced to 0.
- `clear`=1 (synchronous, any state) has highest priority. It returns to IDLE, empties the FIFO, zeroes the counters and suppresses `kernel_start_o`/`done`.
- `start` outside IDLE is ignored.
- Simultaneous push and pop with the FIFO full is not allowed, because ready depends on not-full. With the FIFO at 1 entry, push and pop in the same cycle keep the occupancy at 1.
- Counters are CW bits wide and never exceed `limit` ≤ CNT_LEN, so no wrap occurs.

## Timing
- Kernel launch: `start` sampled at cycle t, `kernel_start_o`=1 at t+1 only.
- FIFO latency: a beat accepted at cycle t is presented on `d_valid_o` at t+1 at the earliest.
- Throughput: 1 beat/cycle when `d_ready_i` is held high.
- Done: the final output handshake at cycle t gives `flags_o.done`=1 at t+1 and `flags_o.ready`=1 at t+2 (if the kernel is idle).
- Zero limit: `start` at t gives `done` at t+1.
- `flags_o.cnt_d` is registered and reflects the handshakes up to the previous cycle.
- Asynchronous reset mid-job immediately forces all reset values. No partial beat is emitted.

## Test plan
- Basic job: limit=4, kernel sends 4 beats back-to-back, `d_ready_i`=1 → data out 1 cycle delayed, `cnt_d`=4, one `done` pulse two cycles after the last input beat, `kernel_start_o` pulsed once.
- Back-pressure: limit=8, `d_ready_i` toggles 1/0 each cycle → `kern_d_ready_o` drops when the FIFO holds 2 beats, all 8 beats arrive in order with no loss or duplication.
- Overrun: limit=3, kernel offers 5 beats → only 3 accepted, `kern_d_ready_o`=0 after the third, `done` after 3 outputs.
- Zero limit: `start` with `cnt_limit_d`=0 → no `kernel_start_o`, `done` at t+1, `cnt_d`=0.
- Clear mid-job: limit=10, `clear` after 5 outputs with 2 beats buffered → next cycle IDLE, FIFO empty, `cnt_d`=0, no `done`. A following job with limit=2 completes normally.
- Enable stall and reset: `enable`=0 for 3 cycles mid-job freezes `cnt_d` and valid/ready. Asserting `rst_ni`=0 mid-job zeroes all outputs asynchronously and leaves `ready`=1 after release.
